// File: rtl/mmac_operand_loader.sv
// Operand loader for the matrix MAC: collects A then B elements from a
// beat stream, packs them row-major ([0][0] in MSBs) and issues the pair.
module mmac_operand_loader #(
   parameter int M_SIZE     = 4,
   parameter int VAR_WIDTH  = 8,
   parameter int DATA_WIDTH = M_SIZE * M_SIZE * VAR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [VAR_WIDTH-1:0]  s_data,
   input  logic                  s_last,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] matrixA,
   output logic [DATA_WIDTH-1:0] matrixB,
   output logic                  err
);

   localparam int NE = M_SIZE * M_SIZE;
   localparam int IW = (NE > 1) ? $clog2(NE) : 1;

   localparam logic [1:0] LOAD_A = 2'd0;
   localparam logic [1:0] LOAD_B = 2'd1;
   localparam logic [1:0] ISSUE  = 2'd2;

   logic [1:0]    state;
   logic [IW-1:0] idx;
   logic          beat;
   logic          last_slot;
   logic          want_last;

   // Handshake outputs: both decoded from state, flush/reset block them.
   assign s_ready   = rst && !flush && (state != ISSUE);
   assign m_valid   = (state == ISSUE) && !flush;
   assign beat      = s_valid && s_ready;
   assign last_slot = (idx == IW'(NE - 1));
   assign want_last = (state == LOAD_B) && last_slot;

   // Sequencing, slot writes and framing-error tracking.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= LOAD_A;
         idx     <= '0;
         matrixA <= '0;
         matrixB <= '0;
         err     <= 1'b0;
      end else if (flush) begin
         state <= LOAD_A;
         idx   <= '0;
      end else begin
         case (state)
            LOAD_A, LOAD_B: begin
               if (beat) begin
                  for (int i = 0; i < NE; i++) begin
                     if (idx == IW'(i)) begin
                        if (state == LOAD_A)
                           matrixA[DATA_WIDTH-1-i*VAR_WIDTH -: VAR_WIDTH] <= s_data;
                        else
                           matrixB[DATA_WIDTH-1-i*VAR_WIDTH -: VAR_WIDTH] <= s_data;
                     end
                  end
                  if (s_last != want_last) begin
                     // misframed pair: drop it and resynchronise on A
                     err   <= 1'b1;
                     state <= LOAD_A;
                     idx   <= '0;
                  end else if (last_slot) begin
                     state <= (state == LOAD_A) ? LOAD_B : ISSUE;
                     idx   <= '0;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (m_ready)
                  state <= LOAD_A;
            end
            default: begin
               state <= LOAD_A;
               idx   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mmac_operand_loader.sv
// Scoreboard bench for mmac_operand_loader: expected pairs are queued
// as stimulus is driven and compared when the DUT issues them.
module tb_mmac_operand_loader;

   logic         clk = 1'b0;
   logic         rst;
   logic         flush;
   logic         s_valid;
   logic         s_ready;
   logic [7:0]   s_data;
   logic         s_last;
   logic         m_valid;
   logic         m_ready;
   logic [127:0] matrixA;
   logic [127:0] matrixB;
   logic         err;

   int checks = 0;
   int errors = 0;
   logic [255:0] sb[$];

   mmac_operand_loader dut (
      .clk(clk), .rst(rst), .flush(flush),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
      .matrixA(matrixA), .matrixB(matrixB), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] obs,
                        input logic [255:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Compare each issued pair against the oldest queued expectation.
   always @(negedge clk) begin
      if (rst && m_valid && m_ready && !flush) begin
         if (sb.size() == 0)
            check("unexpected_issue", {matrixA, matrixB}, '0);
         else
            check("pair", {matrixA, matrixB}, sb.pop_front());
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [7:0] d, input logic l, input int gap);
      bit ok;
      s_valid = 1'b0;
      repeat (gap) step();
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      ok = 1'b0;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk);
         ok = s_ready;
         step();
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (!ok) check("beat_timeout", 0, 1);
   endtask

   function automatic logic [127:0] pack(input logic [7:0] e[16]);
      logic [127:0] p;
      p = '0;
      for (int k = 0; k < 16; k++) p[127-8*k -: 8] = e[k];
      return p;
   endfunction

   task automatic send_pair(input logic [7:0] a[16], input logic [7:0] b[16],
                            input int gmax);
      sb.push_back({pack(a), pack(b)});
      for (int k = 0; k < 16; k++) put(a[k], 1'b0, $urandom_range(0, gmax));
      for (int k = 0; k < 16; k++) put(b[k], k == 15, $urandom_range(0, gmax));
      check("issue_latency", m_valid, 1);
   endtask

   logic [7:0]   a[16];
   logic [7:0]   b[16];
   logic [255:0] snap;

   task automatic rand_ops();
      for (int k = 0; k < 16; k++) begin
         a[k] = 8'($urandom);
         b[k] = 8'($urandom);
      end
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0;
      s_last = 1'b0; m_ready = 1'b1;
      step(); step();
      @(negedge clk);
      check("rst_s_ready", s_ready, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_matrixA", matrixA, 0);
      check("rst_err", err, 0);
      step();
      rst = 1'b1;
      step();

      // 1: ascending A, descending B
      for (int k = 0; k < 16; k++) begin
         a[k] = 8'(k + 1);
         b[k] = 8'(16 - k);
      end
      send_pair(a, b, 0);
      check("a_first", matrixA[127:120], 1);
      check("a_last", matrixA[7:0], 16);
      check("b_first", matrixB[127:120], 16);
      check("b_last", matrixB[7:0], 1);
      step();
      check("post_accept_m_valid", m_valid, 0);
      check("post_accept_s_ready", s_ready, 1);

      // 2: backpressure on the issue side
      m_ready = 1'b0;
      rand_ops();
      send_pair(a, b, 0);
      snap = {matrixA, matrixB};
      repeat (10) begin
         @(negedge clk);
         check("hold_m_valid", m_valid, 1);
         check("hold_s_ready", s_ready, 0);
         check("hold_bus", {matrixA, matrixB}, snap);
      end
      step();
      m_ready = 1'b1;
      step();
      check("release_s_ready", s_ready, 1);
      check("release_m_valid", m_valid, 0);

      // 3: early s_last on beat 20
      for (int k = 0; k <= 20; k++) put(8'(k), k == 20, 0);
      check("early_last_err", err, 1);
      check("early_last_m_valid", m_valid, 0);
      rand_ops();
      send_pair(a, b, 0);
      check("err_sticky", err, 1);

      // 4: flush mid-A, then flush coincident with a beat
      for (int k = 0; k < 7; k++) put(8'hEE, 1'b0, 0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      rand_ops();
      send_pair(a, b, 1);
      step();
      for (int k = 0; k < 3; k++) put(8'hDD, 1'b0, 0);
      flush = 1'b1;
      s_valid = 1'b1;
      s_data = 8'hCC;
      @(negedge clk);
      check("flush_s_ready", s_ready, 0);
      step();
      flush = 1'b0;
      s_valid = 1'b0;
      rand_ops();
      send_pair(a, b, 0);
      step();

      // 5: reset during B beat 5
      rand_ops();
      for (int k = 0; k < 16; k++) put(a[k], 1'b0, 0);
      for (int k = 0; k < 5; k++) put(b[k], 1'b0, 0);
      s_valid = 1'b1;
      s_data = b[5];
      rst = 1'b0;
      @(negedge clk);
      check("midrst_s_ready", s_ready, 0);
      step();
      rst = 1'b1;
      s_valid = 1'b0;
      check("midrst_m_valid", m_valid, 0);
      check("midrst_matrixA", matrixA, 0);
      check("midrst_matrixB", matrixB, 0);
      check("midrst_err", err, 0);
      rand_ops();
      send_pair(a, b, 0);
      step();

      // 6: three back-to-back pairs with random gaps
      for (int p = 0; p < 3; p++) begin
         rand_ops();
         send_pair(a, b, 2);
      end

      for (int n = 0; n < 100 && sb.size() > 0; n++) step();
      check("drain", sb.size(), 0);
      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
